// File: rtl/boot_pkg.sv
// Shared definitions for the IMEM boot loader: FSM encoding and frame constants.
package boot_pkg;

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  // Header byte H encodes a word count of H + HDR_OFS.
  localparam int HDR_OFS        = 1;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream valid/ready link between the host (UART/bench) and the boot loader.
interface imem_boot_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, in_data, input in_ready);
  modport slave  (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/byte_word_packer.sv
// Assembles MSB-first bytes into 32-bit words; word/word_vld are valid in the cycle of the 4th byte.
module byte_word_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_vld
);

  logic [23:0] shreg;
  logic [1:0]  cnt;

  assign word     = {shreg, din};
  assign word_vld = en && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
    end
  end

  // Payload only; the byte counter alone decides when a word is complete.
  always_ff @(posedge clk) begin
    if (en) begin
      shreg <= {shreg[15:0], din};
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a header-framed byte stream into IMEM, then runs the CPU for RUN_CYCLES and freezes it.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int RUN_CYCLES = 50,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_loader_if.slave   bus,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [31:0]         imem_wdata,
  output logic                cpu_reset,
  output logic                cpu_clk_en,
  output logic                done,
  output logic                err
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state, nxt;
  logic              in_ready_q;
  logic              accept;
  logic              hdr_ok, hdr_bad;
  logic              pk_en, pk_clr;
  logic [31:0]       pk_word;
  logic              pk_word_vld;
  logic [ADDR_W-1:0] word_idx, last_idx;
  logic [CNT_W-1:0]  run_cnt;

  function automatic logic hdr_oversize(input logic [7:0] h);
    return (int'(h) + HDR_OFS) > DEPTH;
  endfunction

  assign bus.in_ready = in_ready_q;
  assign accept       = bus.in_valid && in_ready_q;
  assign pk_clr       = hdr_ok;

  byte_word_packer u_packer (
    .clk      (clk),
    .rst      (reset),
    .clr      (pk_clr),
    .en       (pk_en),
    .din      (bus.in_data),
    .word     (pk_word),
    .word_vld (pk_word_vld)
  );

  always_comb begin
    nxt     = state;
    hdr_ok  = 1'b0;
    hdr_bad = 1'b0;
    pk_en   = 1'b0;
    case (state)
      S_HDR, S_DONE: begin
        if (accept) begin
          if (hdr_oversize(bus.in_data)) begin
            hdr_bad = 1'b1;
          end else begin
            hdr_ok = 1'b1;
            nxt    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        pk_en = accept;
        if (pk_word_vld && (word_idx == last_idx)) nxt = S_FLUSH;
      end
      S_FLUSH: nxt = S_RUN;
      S_RUN: begin
        if (run_cnt == CNT_W'(RUN_CYCLES - 1)) nxt = S_DONE;
      end
      default: nxt = S_HDR;
    endcase
  end

  // Outputs are registered decodes of the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_HDR;
      in_ready_q <= 1'b1;
      cpu_reset  <= 1'b1;
      cpu_clk_en <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_idx   <= '0;
      last_idx   <= '0;
      run_cnt    <= '0;
    end else begin
      state      <= nxt;
      in_ready_q <= (nxt != S_FLUSH) && (nxt != S_RUN);
      cpu_reset  <= (nxt == S_HDR) || (nxt == S_LOAD) || (nxt == S_FLUSH);
      cpu_clk_en <= (nxt == S_RUN);
      done       <= (nxt == S_DONE);
      imem_we    <= pk_word_vld;
      if (hdr_bad) err <= 1'b1;
      if (pk_word_vld) begin
        imem_addr  <= word_idx;
        imem_wdata <= pk_word;
        word_idx   <= word_idx + 1'b1;
      end
      if (hdr_ok) begin
        last_idx <= ADDR_W'(bus.in_data);
        word_idx <= '0;
      end
      run_cnt <= ((state == S_RUN) && (nxt == S_RUN)) ? run_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: framing, errors, stalls, reset abort, full-depth load.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset, cpu_clk_en, done, err;

  int total = 0;
  int bad   = 0;

  logic [5:0]  wa[$];
  logic [31:0] wd[$];

  imem_boot_loader_if bus ();

  imem_boot_loader #(.ADDR_W(6), .RUN_CYCLES(50), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .cpu_clk_en (cpu_clk_en),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready) begin
      if (n++ > 200) begin
        chk("ready_timeout", 32'(bus.in_ready), 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8],  gap);
    send_byte(w[7:0],   gap);
  endtask

  // Entered on the negedge right after the last payload byte was accepted.
  task automatic run_check(input string tag);
    int n = 1;
    int guard = 0;
    chk({tag, "_flush_rst"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_flush_rdy"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_flush_en"}, 32'(cpu_clk_en), 32'd0);
    @(negedge clk);
    chk({tag, "_run_rst"}, 32'(cpu_reset), 32'd0);
    chk({tag, "_run_en"}, 32'(cpu_clk_en), 32'd1);
    while (!done && guard < 500) begin
      @(negedge clk);
      if (cpu_clk_en) n++;
      guard++;
    end
    chk({tag, "_run_len"}, 32'(n), 32'd50);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_done_en"}, 32'(cpu_clk_en), 32'd0);
    chk({tag, "_done_rst"}, 32'(cpu_reset), 32'd0);
    chk({tag, "_done_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  function automatic logic [31:0] full_word(input int i);
    return {8'(i), 8'hC3, 8'(255 - i), 8'(i * 3)};
  endfunction

  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_000C;
    prog[2] = 32'h0109_5020;

    // Reset state
    do_reset();
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cpurst", 32'(cpu_reset), 32'd1);
    chk("rst_en", 32'(cpu_clk_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Three-word program
    send_byte(8'h02, 0);
    for (int i = 0; i < 3; i++) send_word(prog[i], 0);
    run_check("prog");
    chk("prog_nwr", 32'(wa.size()), 32'd3);
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      chk($sformatf("prog_addr%0d", i), 32'(wa[i]), 32'(i));
      chk($sformatf("prog_data%0d", i), wd[i], prog[i]);
    end

    // Oversize header from S_HDR, then a valid single-word load
    do_reset();
    send_byte(8'h40, 0);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_rdy", 32'(bus.in_ready), 32'd1);
    chk("ovf_cpurst", 32'(cpu_reset), 32'd1);
    repeat (3) @(negedge clk);
    chk("ovf_nwr", 32'(wa.size()), 32'd0);
    send_byte(8'h00, 0);
    send_word(32'hDEAD_BEEF, 0);
    run_check("one");
    chk("one_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() > 0) begin
      chk("one_addr", 32'(wa[0]), 32'd0);
      chk("one_data", wd[0], 32'hDEAD_BEEF);
    end
    chk("one_err_sticky", 32'(err), 32'd1);

    // From S_DONE: oversize header keeps done, valid header restarts
    wa.delete(); wd.delete();
    send_byte(8'hFF, 0);
    chk("dn_ovf_done", 32'(done), 32'd1);
    chk("dn_ovf_err", 32'(err), 32'd1);
    chk("dn_ovf_rst", 32'(cpu_reset), 32'd0);
    send_byte(8'h00, 0);
    chk("dn_hdr_done", 32'(done), 32'd0);
    chk("dn_hdr_rst", 32'(cpu_reset), 32'd1);
    send_word(32'h0000_0000, 0);
    run_check("rerun");
    chk("rerun_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() > 0) begin
      chk("rerun_addr", 32'(wa[0]), 32'd0);
      chk("rerun_data", wd[0], 32'h0000_0000);
    end

    // Stalled stream: valid every other cycle
    do_reset();
    chk("stall_err_clr", 32'(err), 32'd0);
    send_byte(8'h01, 1);
    send_word(32'hAABB_CCDD, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    send_byte(8'h33, 1);
    send_byte(8'h44, 0);
    run_check("stall");
    chk("stall_nwr", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk("stall_a0", 32'(wa[0]), 32'd0);
      chk("stall_d0", wd[0], 32'hAABB_CCDD);
      chk("stall_a1", 32'(wa[1]), 32'd1);
      chk("stall_d1", wd[1], 32'h1122_3344);
    end

    // Reset mid-load after six payload bytes
    do_reset();
    send_byte(8'h02, 0);
    send_word(32'h0102_0304, 0);
    send_byte(8'h05, 0);
    send_byte(8'h06, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_rdy", 32'(bus.in_ready), 32'd1);
    chk("abort_we", 32'(imem_we), 32'd0);
    chk("abort_addr", 32'(imem_addr), 32'd0);
    chk("abort_wdata", imem_wdata, 32'd0);
    chk("abort_cpurst", 32'(cpu_reset), 32'd1);
    chk("abort_en", 32'(cpu_clk_en), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() > 0) chk("abort_d0", wd[0], 32'h0102_0304);

    // Full-depth load
    do_reset();
    send_byte(8'h3F, 0);
    for (int i = 0; i < 64; i++) send_word(full_word(i), 0);
    run_check("full");
    chk("full_nwr", 32'(wa.size()), 32'd64);
    for (int i = 0; i < 64 && i < wa.size(); i++) begin
      chk($sformatf("full_addr%0d", i), 32'(wa[i]), 32'(i));
      chk($sformatf("full_data%0d", i), wd[i], full_word(i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
